pic: RTL and testbench

- Interrupt controller; 8259A-compatible subset. Sits on the chipset I/O bus at 0x20/0x21.
- Consumes the timer's OUT0 and the other chipset interrupt lines on iIrq[7:0].
- Raises oIntr to the CPU core and returns the interrupt vector during the acknowledge handshake.
- Single-controller mode, edge-triggered inputs, fixed priority (IRQ0 highest).

---
 rtl/pic_pkg.sv | 34 +++
 rtl/pic_if.sv | 28 ++
 rtl/pic_prio.sv | 32 +++
 rtl/pic.sv | 178 +++++++++++++++++
 tb/tb_pic.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the interrupt controller.
//   - init_state_t : initialisation sequence states
//   - control-word decode bit positions (ICW1/ICW4/OCW2/OCW3)
//   - OCW2 EOI command codes, read-select constants
//   - clear_lowest(): drops the lowest-numbered set bit (non-specific EOI)
package pic_pkg;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_ICW2  = 2'd1,
        ST_ICW3  = 2'd2,
        ST_ICW4  = 2'd3
    } init_state_t;

    // A0=0 command byte decode
    localparam int ICW1_BIT      = 4;  // 1: ICW1, 0: OCW2/OCW3
    localparam int ICW1_SNGL_BIT = 1;
    localparam int ICW1_IC4_BIT  = 0;
    localparam int OCW3_BIT      = 3;  // with ICW1_BIT=0: 1 selects OCW3
    localparam int OCW3_RR_BIT   = 1;  // read-register command enable
    localparam int OCW3_RIS_BIT  = 0;  // 0 = IRR, 1 = ISR
    localparam int ICW4_AEOI_BIT = 1;

    localparam logic [2:0] EOI_NONSPEC = 3'b001;
    localparam logic [2:0] EOI_SPEC    = 3'b011;

    localparam logic RDSEL_IRR = 1'b0;
    localparam logic RDSEL_ISR = 1'b1;

    function automatic logic [7:0] clear_lowest(input logic [7:0] v);
        return v & (v - 8'd1);
    endfunction

endpackage

// File: rtl/pic_if.sv
// pic_if: CPU-side I/O bus and interrupt-acknowledge signals of the PIC.
//   iAddr/iData/iWr/iRd : I/O write/read access
//   oData/oSel          : registered read data and read-hit flag
//   iIntAck             : acknowledge pulse from the CPU
//   oIntr/oVector/oVecValid : interrupt request and returned vector
// master = CPU/chipset side, slave = the controller.
interface pic_if;
    logic [11:0] iAddr;
    logic [7:0]  iData;
    logic        iWr;
    logic        iRd;
    logic        iIntAck;
    logic        oIntr;
    logic [7:0]  oVector;
    logic        oVecValid;
    logic [7:0]  oData;
    logic        oSel;

    modport master (
        output iAddr, iData, iWr, iRd, iIntAck,
        input  oIntr, oVector, oVecValid, oData, oSel
    );

    modport slave (
        input  iAddr, iData, iWr, iRd, iIntAck,
        output oIntr, oVector, oVecValid, oData, oSel
    );
endinterface

// File: rtl/pic_prio.sv
// pic_prio: 8-level fixed-priority resolver, level 0 highest.
//   i_irr, i_imr, i_isr : request, mask and in-service registers
//   o_req               : an unmasked request is allowed through
//   o_level             : winning level (7 when o_req is low)
module pic_prio (
    input  logic [7:0] i_irr,
    input  logic [7:0] i_imr,
    input  logic [7:0] i_isr,
    output logic       o_req,
    output logic [2:0] o_level
);
    logic [7:0] w_cand;

    // A level is a candidate when it is pending, unmasked and no level of
    // equal or higher priority is in service. The lowest candidate is also
    // the lowest eligible level, so a plain priority pick is enough.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cand
            assign w_cand[gi] = i_irr[gi] & ~i_imr[gi] & ~(|i_isr[gi:0]);
        end
    endgenerate

    always_comb begin
        o_level = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (w_cand[i]) o_level = 3'(i);
        end
    end

    assign o_req = |w_cand;
endmodule

// File: rtl/pic.sv
// pic: 8259A-style interrupt controller subset (single, edge-triggered,
// fixed priority).
//   iClk, iRstN : clock, asynchronous active-low reset
//   iIrq[7:0]   : request lines, rising edge requests
//   bus         : pic_if.slave - I/O access at BASE_ADDR/BASE_ADDR+1,
//                 oIntr to the CPU, vector returned after iIntAck
module pic
    import pic_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR   = 12'h020,
    parameter logic [4:0]  RESET_VBASE = 5'h01
) (
    input  logic       iClk,
    input  logic       iRstN,
    input  logic [7:0] iIrq,
    pic_if.slave       bus
);
    init_state_t r_state, w_state_next;
    logic [7:0]  r_irr, r_isr, r_imr, r_irq_prev;
    logic [4:0]  r_vbase;
    logic        r_aeoi, r_rdsel, r_sngl, r_ic4;
    logic        r_intr, r_vec_valid, r_sel;
    logic [7:0]  r_vector, r_data;

    logic [7:0]  w_irr_next, w_isr_next, w_imr_next, w_isr_eoi, w_vector_next;
    logic [4:0]  w_vbase_next;
    logic        w_aeoi_next, w_rdsel_next, w_sngl_next, w_ic4_next;

    logic        w_hit, w_a0, w_wr_a0, w_wr_a1, w_icw1, w_ocw2, w_ocw3, w_rd_hit;
    logic [7:0]  w_edges;
    logic        w_intr_req, w_ack_req;
    logic [2:0]  w_intr_level_unused, w_ack_level;

    assign w_hit    = ({bus.iAddr[11:1], 1'b0} == BASE_ADDR);
    assign w_a0     = bus.iAddr[0];
    assign w_wr_a0  = bus.iWr & w_hit & ~w_a0;
    assign w_wr_a1  = bus.iWr & w_hit & w_a0;
    assign w_rd_hit = bus.iRd & w_hit;
    assign w_icw1   = w_wr_a0 & bus.iData[ICW1_BIT];
    assign w_ocw2   = w_wr_a0 & (r_state == ST_READY) & ~bus.iData[ICW1_BIT] & ~bus.iData[OCW3_BIT];
    assign w_ocw3   = w_wr_a0 & (r_state == ST_READY) & ~bus.iData[ICW1_BIT] &  bus.iData[OCW3_BIT];
    assign w_edges  = iIrq & ~r_irq_prev;

    // ISR with this cycle's EOI already applied; the acknowledge path
    // resolves against it so an EOI and an ack in one cycle act in order.
    always_comb begin
        w_isr_eoi = r_isr;
        if (w_ocw2) begin
            case (bus.iData[7:5])
                EOI_NONSPEC: w_isr_eoi = clear_lowest(r_isr);
                EOI_SPEC:    w_isr_eoi[bus.iData[2:0]] = 1'b0;
                default:     w_isr_eoi = r_isr;
            endcase
        end
    end

    // oIntr follows the registers one cycle late; ack sees the EOI result.
    pic_prio u_prio_intr (
        .i_irr   (r_irr),
        .i_imr   (r_imr),
        .i_isr   (r_isr),
        .o_req   (w_intr_req),
        .o_level (w_intr_level_unused)
    );

    pic_prio u_prio_ack (
        .i_irr   (r_irr),
        .i_imr   (r_imr),
        .i_isr   (w_isr_eoi),
        .o_req   (w_ack_req),
        .o_level (w_ack_level)
    );

    always_comb begin
        w_state_next  = r_state;
        w_irr_next    = r_irr;
        w_isr_next    = w_isr_eoi;
        w_imr_next    = r_imr;
        w_vbase_next  = r_vbase;
        w_aeoi_next   = r_aeoi;
        w_rdsel_next  = r_rdsel;
        w_sngl_next   = r_sngl;
        w_ic4_next    = r_ic4;
        w_vector_next = 8'h00;

        if (bus.iIntAck) begin
            if (w_icw1 || !w_ack_req) begin
                w_vector_next = {r_vbase, 3'd7};   // spurious
            end else begin
                w_vector_next = {r_vbase, w_ack_level};
                w_irr_next[w_ack_level] = 1'b0;
                if (!r_aeoi) w_isr_next[w_ack_level] = 1'b1;
            end
        end

        if (w_icw1) begin
            w_irr_next   = 8'h00;
            w_isr_next   = 8'h00;
            w_imr_next   = 8'h00;
            w_aeoi_next  = 1'b0;
            w_rdsel_next = RDSEL_IRR;
            w_sngl_next  = bus.iData[ICW1_SNGL_BIT];
            w_ic4_next   = bus.iData[ICW1_IC4_BIT];
            w_state_next = ST_ICW2;
        end else if (w_wr_a1) begin
            case (r_state)
                ST_READY: w_imr_next = bus.iData;
                ST_ICW2: begin
                    w_vbase_next = bus.iData[7:3];
                    if (!r_sngl)    w_state_next = ST_ICW3;
                    else if (r_ic4) w_state_next = ST_ICW4;
                    else            w_state_next = ST_READY;
                end
                ST_ICW3:  w_state_next = r_ic4 ? ST_ICW4 : ST_READY;
                ST_ICW4: begin
                    w_aeoi_next  = bus.iData[ICW4_AEOI_BIT];
                    w_state_next = ST_READY;
                end
                default:  w_state_next = ST_READY;
            endcase
        end else if (w_ocw3 && bus.iData[OCW3_RR_BIT]) begin
            w_rdsel_next = bus.iData[OCW3_RIS_BIT];
        end

        // A fresh edge always wins over a clear in the same cycle.
        w_irr_next = w_irr_next | w_edges;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_irr       <= 8'h00;
            r_isr       <= 8'h00;
            r_imr       <= 8'hFF;
            r_irq_prev  <= 8'h00;
            r_vbase     <= RESET_VBASE;
            r_aeoi      <= 1'b0;
            r_rdsel     <= RDSEL_IRR;
            r_sngl      <= 1'b0;
            r_ic4       <= 1'b0;
            r_intr      <= 1'b0;
            r_vec_valid <= 1'b0;
            r_vector    <= 8'h00;
            r_sel       <= 1'b0;
            r_data      <= 8'h00;
        end else begin
            r_irr       <= w_irr_next;
            r_isr       <= w_isr_next;
            r_imr       <= w_imr_next;
            r_irq_prev  <= iIrq;
            r_vbase     <= w_vbase_next;
            r_aeoi      <= w_aeoi_next;
            r_rdsel     <= w_rdsel_next;
            r_sngl      <= w_sngl_next;
            r_ic4       <= w_ic4_next;
            r_intr      <= w_intr_req;
            r_vec_valid <= bus.iIntAck;
            r_vector    <= w_vector_next;
            r_sel       <= w_rd_hit;
            if (!w_rd_hit)  r_data <= 8'h00;
            else if (w_a0)  r_data <= r_imr;
            else            r_data <= r_rdsel ? r_isr : r_irr;
        end
    end

    assign bus.oIntr     = r_intr;
    assign bus.oVector   = r_vector;
    assign bus.oVecValid = r_vec_valid;
    assign bus.oSel      = r_sel;
    assign bus.oData     = r_data;
endmodule

// File: tb/tb_pic.sv
// tb_pic: randomized + directed bench for pic with a behavioural model
// and queue-based scoreboard.
module tb_pic;
    logic       clk;
    logic       rst_n;
    logic [7:0] irq;

    pic_if bus ();

    pic #(.BASE_ADDR(12'h020), .RESET_VBASE(5'h01)) u_dut (
        .iClk  (clk),
        .iRstN (rst_n),
        .iIrq  (irq),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        bit intr;
        bit vv;
        bit sel;
    } cyc_t;

    cyc_t     cyc_q[$];
    bit [7:0] vec_q[$];
    bit [7:0] rd_q[$];

    // behavioural model state
    bit [7:0] m_irr, m_isr, m_imr, m_prev;
    bit [4:0] m_vb;
    bit       m_aeoi, m_rdsel, m_sngl, m_ic4;
    int       m_st;     // 0 ready, 1 expect ICW2, 2 expect ICW3, 3 expect ICW4
    bit [7:0] cur_irq;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_prev = 0; m_vb = 5'h01;
        m_aeoi = 0; m_rdsel = 0; m_sngl = 0; m_ic4 = 0; m_st = 0;
    endtask

    // Highest-priority request that may interrupt: scan from level 0;
    // an in-service level blocks itself and everything below it.
    function automatic int winner(bit [7:0] rr, bit [7:0] mr, bit [7:0] sr);
        for (int n = 0; n < 8; n++) begin
            if (sr[n]) return -1;
            if (rr[n] && !mr[n]) return n;
        end
        return -1;
    endfunction

    task automatic step(input bit wr, input bit rd, input bit ack,
                        input bit [11:0] addr, input bit [7:0] data, input bit [7:0] irq_v);
        bit       hit, a0, icw1, found;
        bit [7:0] edges;
        int       w;
        cyc_t     e;
        @(negedge clk);
        bus.iWr = wr; bus.iRd = rd; bus.iIntAck = ack;
        bus.iAddr = addr; bus.iData = data; irq = irq_v;
        $display("cyc wr=%0b rd=%0b ack=%0b addr=%03h data=%02h irq=%02h", wr, rd, ack, addr, data, irq_v);

        hit = (addr[11:1] == 11'h010);
        a0  = addr[0];
        e.intr = (winner(m_irr, m_imr, m_isr) >= 0);
        e.vv   = ack;
        e.sel  = rd && hit;
        cyc_q.push_back(e);
        if (rd && hit) rd_q.push_back(a0 ? m_imr : (m_rdsel ? m_isr : m_irr));

        edges  = irq_v & ~m_prev;
        m_prev = irq_v;
        icw1   = wr && hit && !a0 && data[4];

        if (wr && hit && !a0 && !data[4] && !data[3] && m_st == 0) begin
            if (data[7:5] == 3'd1) begin
                found = 0;
                for (int n = 0; n < 8; n++) begin
                    if (!found && m_isr[n]) begin m_isr[n] = 0; found = 1; end
                end
            end else if (data[7:5] == 3'd3) begin
                m_isr[data[2:0]] = 0;
            end
        end

        if (ack) begin
            w = icw1 ? -1 : winner(m_irr, m_imr, m_isr);
            if (w < 0) vec_q.push_back({m_vb, 3'd7});
            else begin
                vec_q.push_back({m_vb, 3'(w)});
                m_irr[w] = 0;
                if (!m_aeoi) m_isr[w] = 1;
            end
        end

        if (icw1) begin
            m_irr = 0; m_isr = 0; m_imr = 0; m_aeoi = 0; m_rdsel = 0;
            m_sngl = data[1]; m_ic4 = data[0]; m_st = 1;
        end else if (wr && hit && a0) begin
            case (m_st)
                0: m_imr = data;
                1: begin m_vb = data[7:3]; m_st = !m_sngl ? 2 : (m_ic4 ? 3 : 0); end
                2: m_st = m_ic4 ? 3 : 0;
                default: begin m_aeoi = data[1]; m_st = 0; end
            endcase
        end else if (wr && hit && !a0 && !data[4] && data[3] && m_st == 0 && data[1]) begin
            m_rdsel = data[0];
        end

        m_irr = m_irr | edges;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 12'h000, 8'h00, cur_irq);
    endtask
    task automatic wr(input bit [11:0] a, input bit [7:0] d);
        step(1, 0, 0, a, d, cur_irq);
    endtask
    task automatic rd(input bit [11:0] a);
        step(0, 1, 0, a, 8'h00, cur_irq);
    endtask
    task automatic ack();
        step(0, 0, 1, 12'h000, 8'h00, cur_irq);
    endtask
    task automatic set_irq(input bit [7:0] v);
        cur_irq = v;
        step(0, 0, 0, 12'h000, 8'h00, cur_irq);
    endtask

    // scoreboard monitor
    initial begin
        cyc_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (cyc_q.size() > 0) begin
                    e = cyc_q.pop_front();
                    chk("oIntr", {7'b0, bus.oIntr}, {7'b0, e.intr});
                    chk("oVecValid", {7'b0, bus.oVecValid}, {7'b0, e.vv});
                    chk("oSel", {7'b0, bus.oSel}, {7'b0, e.sel});
                end
                if (bus.oVecValid) begin
                    if (vec_q.size() == 0) chk("vec_unexpected", 8'd1, 8'd0);
                    else chk("oVector", bus.oVector, vec_q.pop_front());
                end
                if (bus.oSel) begin
                    if (rd_q.size() == 0) chk("rd_unexpected", 8'd1, 8'd0);
                    else chk("oData", bus.oData, rd_q.pop_front());
                end else begin
                    chk("oData_idle", bus.oData, 8'h00);
                end
            end
        end
    end

    initial begin
        int       r;
        bit [7:0] rb;
        bit [11:0] ra;

        rst_n = 0; irq = 0; cur_irq = 0;
        bus.iAddr = 0; bus.iData = 0; bus.iWr = 0; bus.iRd = 0; bus.iIntAck = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oIntr", {7'b0, bus.oIntr}, 8'h00);
        chk("rst_oVector", bus.oVector, 8'h00);
        chk("rst_oVecValid", {7'b0, bus.oVecValid}, 8'h00);
        chk("rst_oData", bus.oData, 8'h00);
        chk("rst_oSel", {7'b0, bus.oSel}, 8'h00);
        @(negedge clk);
        rst_n = 1;

        // 1: init, single request, ack, EOI
        idle(1);
        rd(12'h021);
        wr(12'h020, 8'h13); wr(12'h021, 8'h08); wr(12'h021, 8'h01); wr(12'h021, 8'hFE);
        set_irq(8'h01); set_irq(8'h00); idle(2);
        ack(); idle(2);
        wr(12'h020, 8'h0B); rd(12'h020);
        wr(12'h020, 8'h20); rd(12'h020); wr(12'h020, 8'h0A);

        // 2: priority and nesting
        wr(12'h021, 8'hFC);
        set_irq(8'h02); set_irq(8'h00); set_irq(8'h01); set_irq(8'h00); idle(2);
        ack(); idle(3);
        wr(12'h020, 8'h20); idle(2);
        ack(); idle(2); wr(12'h020, 8'h20); idle(1);

        // 3: held level requests once; spurious ack
        cur_irq = 8'h01; idle(100); set_irq(8'h00);
        ack(); idle(2); ack(); idle(1);
        wr(12'h020, 8'h0B); rd(12'h020); wr(12'h020, 8'h20);

        // 4: register readback and out-of-range read
        set_irq(8'h02); set_irq(8'h00);
        wr(12'h021, 8'hFF);
        wr(12'h020, 8'h0A); rd(12'h020);
        wr(12'h020, 8'h0B); rd(12'h020);
        rd(12'h021); rd(12'h060); rd(12'h061); idle(1);

        // 5: automatic EOI
        wr(12'h020, 8'h13); wr(12'h021, 8'h08); wr(12'h021, 8'h03); wr(12'h021, 8'hFC);
        set_irq(8'h01); set_irq(8'h00); idle(2);
        ack(); set_irq(8'h02); set_irq(8'h00); idle(2);
        ack(); idle(2);
        wr(12'h020, 8'h0B); rd(12'h020);

        // 6: reset between ICW1 and ICW2 with a request pending
        wr(12'h020, 8'h11); set_irq(8'h08); set_irq(8'h00);
        @(posedge clk); #2;
        rst_n = 0;
        #2;
        chk("midrst_oIntr", {7'b0, bus.oIntr}, 8'h00);
        chk("midrst_oSel", {7'b0, bus.oSel}, 8'h00);
        chk("midrst_oVecValid", {7'b0, bus.oVecValid}, 8'h00);
        model_reset();
        bus.iWr = 0; bus.iRd = 0; bus.iIntAck = 0;
        @(negedge clk);
        rst_n = 1;
        rd(12'h021); rd(12'h020);
        wr(12'h021, 8'h00); rd(12'h021);
        set_irq(8'h04); set_irq(8'h00); idle(2); ack(); idle(2);

        // random phase
        wr(12'h020, 8'h13); wr(12'h021, 8'h40); wr(12'h021, 8'h01); wr(12'h021, 8'h00);
        for (int it = 0; it < 3000; it++) begin
            r  = $urandom_range(0, 99);
            rb = 8'($urandom);
            if (r < 25) begin
                idle(1);
            end else if (r < 45) begin
                cur_irq = cur_irq ^ (8'h01 << $urandom_range(0, 7));
                idle(1);
            end else if (r < 57) begin
                if (rb[7:6] == 2'b00) cur_irq = cur_irq ^ (8'h01 << $urandom_range(0, 7));
                ack();
            end else if (r < 64) begin
                wr(12'h020, 8'h20);
            end else if (r < 68) begin
                wr(12'h020, {5'b01100, rb[2:0]});
            end else if (r < 72) begin
                wr(12'h021, rb & 8'($urandom));
            end else if (r < 80) begin
                case (rb[2:0])
                    3'd0, 3'd1: ra = 12'h020;
                    3'd2, 3'd3: ra = 12'h021;
                    3'd4:       ra = 12'h060;
                    3'd5:       ra = 12'h061;
                    default:    ra = 12'h022;
                endcase
                rd(ra);
            end else if (r < 84) begin
                wr(12'h020, {7'b0000101, rb[0]});
            end else if (r < 86) begin
                wr(12'h020, {6'b000100, rb[1:0]});
                wr(12'h021, 8'($urandom));
                if (!rb[1]) wr(12'h021, 8'h00);
                if (rb[0])  wr(12'h021, {6'b0, rb[2], 1'b1});
                wr(12'h021, 8'h00);
            end else if (r < 92) begin
                step(1, 0, 1, 12'h020, rb[4] ? 8'h20 : {5'b01100, rb[2:0]}, cur_irq);
            end else if (r < 94) begin
                step(1, 0, 1, 12'h020, 8'h13, cur_irq);
            end else begin
                wr({11'h010, rb[0]}, 8'($urandom));
            end
        end
        idle(3);
        @(posedge clk); #3;
        chk("cyc_q_left", 8'(cyc_q.size()), 8'h00);
        chk("vec_q_left", 8'(vec_q.size()), 8'h00);
        chk("rd_q_left", 8'(rd_q.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
